// File: rtl/imsharp_pkg.sv
// imsharp_pkg: shared constants and the window slot-index helper for the
// 5x5 sharpening window. Slot k = 5*r + c + 1, where r = 0 is the oldest
// (top) row and c = 0 is the oldest (left) column.
package imsharp_pkg;

    localparam int WIN_SIZE  = 5;
    localparam int WIN_PIX   = WIN_SIZE * WIN_SIZE;
    localparam int DEF_PIX_W = 8;

    // 1-based slot number for window row r, column c.
    function automatic int slot_k(input int r, input int c);
        return WIN_SIZE * r + c + 1;
    endfunction

endpackage

// File: rtl/imsharp_line_buffer.sv
// imsharp_line_buffer: one image line of delay. The read is combinational
// from the current column address, and the write to that address lands on
// the same edge. A read therefore sees the pixel written one line earlier.
// The storage is deliberately not reset. Upstream row masking keeps stale
// contents out of any valid window.
module imsharp_line_buffer #(
    parameter int IMG_WIDTH = 64,
    parameter int PIX_W     = 8
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic [$clog2(IMG_WIDTH)-1:0] addr,
    input  logic [PIX_W-1:0]             din,
    output logic [PIX_W-1:0]             dout
);

    logic [PIX_W-1:0] mem [IMG_WIDTH];

    assign dout = mem[addr];

    // Overwrite the column slot with the current line's pixel.
    always_ff @(posedge clk) begin
        if (en) mem[addr] <= din;
    end

endmodule

// File: rtl/imsharp_window.sv
// imsharp_window: raster-stream 5x5 window generator for the sharpening
// stage. Four cascaded line buffers supply the four previous lines at the
// current column. The 5x5 register array shifts one column left for each
// accepted pixel. window_valid is asserted one cycle after a pixel at
// row >= 4 and col >= 4, so windows never straddle a line boundary.
// Optional feature: define IMSHARP_WIN_CNT_EN to add the win_count output.
// win_count is a saturating count of valid windows since the last sof or
// reset.
module imsharp_window
    import imsharp_pkg::*;
#(
    parameter int IMG_WIDTH = 64,
    parameter int PIX_W     = DEF_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PIX_W-1:0]         pixel_in,
    input  logic                     pixel_valid,
    input  logic                     sof,
    output logic [WIN_PIX*PIX_W-1:0] window_out,
    output logic                     window_valid
`ifdef IMSHARP_WIN_CNT_EN
    ,
    output logic [15:0]              win_count
`endif
);

    localparam int            CW       = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] EDGE_COL = CW'(WIN_SIZE - 1);
    localparam logic [2:0]    FULL_ROW = 3'(WIN_SIZE - 1);

    logic [CW-1:0] col, cur_col;
    logic [2:0]    row, cur_row;
    logic          hit;

    // lb_chain[0] is the incoming pixel. lb_chain[i+1] is line R-(i+1).
    logic [PIX_W-1:0] lb_chain [WIN_SIZE];

    logic [WIN_PIX-1:0][PIX_W-1:0] win;

    // An accepted sof pixel sits at (0,0) whatever the counters say.
    // Using that forced position for the line-buffer address restarts the
    // frame cleanly.
    always_comb begin
        cur_col = sof ? '0 : col;
        cur_row = sof ? '0 : row;
        hit     = pixel_valid && (cur_row == FULL_ROW) && (cur_col >= EDGE_COL);
    end

    assign lb_chain[0] = pixel_in;

    for (genvar i = 0; i < WIN_SIZE - 1; i++) begin : g_lb
        imsharp_line_buffer #(
            .IMG_WIDTH (IMG_WIDTH),
            .PIX_W     (PIX_W)
        ) u_lb (
            .clk  (clk),
            .en   (pixel_valid),
            .addr (cur_col),
            .din  (lb_chain[i]),
            .dout (lb_chain[i+1])
        );
    end

    // Column and row position. The row only needs to reach 4, so it
    // saturates there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pixel_valid) begin
            if (cur_col == LAST_COL) begin
                col <= '0;
                row <= (cur_row < FULL_ROW) ? cur_row + 3'd1 : cur_row;
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    // Window shift: each row moves one column left. The new right column
    // takes the oldest line at the top and the live pixel at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (pixel_valid) begin
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE - 1; c++)
                    win[slot_k(r, c) - 1] <= win[slot_k(r, c + 1) - 1];
                win[slot_k(r, WIN_SIZE - 1) - 1] <= lb_chain[WIN_SIZE - 1 - r];
            end
        end
    end

    // window_valid has one-cycle latency. An idle cycle drops it to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) window_valid <= 1'b0;
        else        window_valid <= hit;
    end

    assign window_out = win;

`ifdef IMSHARP_WIN_CNT_EN
    // Saturating count of valid windows. An accepted sof clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          win_count <= '0;
        else if (pixel_valid && sof)         win_count <= '0;
        else if (hit && win_count != 16'hFFFF) win_count <= win_count + 16'd1;
    end
`endif

endmodule
